// File: rtl/fl_fifo_status_gen_if.sv
// rtl/fl_fifo_status_gen_if.sv - FrameLink FIFO request/accept/status bundle (ERR present with FL_FIFO_STATUS_ERR_EN)
interface fl_fifo_status_gen_if #(
    parameter int STATUS_WIDTH = 4
);
    logic                    WR_REQ;
    logic                    WR_EOF;
    logic                    RD_REQ;
    logic                    RD_EOF;
    logic                    WR_ACCEPT;
    logic                    RD_ACCEPT;
    logic                    LSTBLK;
    logic [STATUS_WIDTH-1:0] STATUS;
    logic                    EMPTY;
    logic                    FULL;
    logic                    FRAME_RDY;
`ifdef FL_FIFO_STATUS_ERR_EN
    logic                    ERR;
`endif

    modport master (
        output WR_REQ, WR_EOF, RD_REQ, RD_EOF,
        input  WR_ACCEPT, RD_ACCEPT, LSTBLK, STATUS, EMPTY, FULL, FRAME_RDY
`ifdef FL_FIFO_STATUS_ERR_EN
        , input ERR
`endif
    );

    modport slave (
        input  WR_REQ, WR_EOF, RD_REQ, RD_EOF,
        output WR_ACCEPT, RD_ACCEPT, LSTBLK, STATUS, EMPTY, FULL, FRAME_RDY
`ifdef FL_FIFO_STATUS_ERR_EN
        , output ERR
`endif
    );
endinterface

// File: rtl/fl_fifo_status_gen.sv
// rtl/fl_fifo_status_gen.sv - FrameLink FIFO status generator; optional ERR output with FL_FIFO_STATUS_ERR_EN
module fl_fifo_status_gen #(
    parameter int ITEMS        = 64,
    parameter int BLOCK_SIZE   = 4,
    parameter int STATUS_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    fl_fifo_status_gen_if.slave  bus
);
    localparam int                     CNT_W      = $clog2(ITEMS) + 1;
    localparam logic [CNT_W-1:0]       ITEMS_C    = CNT_W'(ITEMS);
    localparam logic [CNT_W-1:0]       BLOCK_C    = CNT_W'(BLOCK_SIZE);
    localparam logic [STATUS_WIDTH-1:0] STATUS_RST = ITEMS_C[CNT_W-1 -: STATUS_WIDTH];

    logic [CNT_W-1:0]        cnt, fcnt;
    logic [CNT_W-1:0]        cnt_next, fcnt_next, free_next;
    logic                    empty_r, full_r, frame_rdy_r, lstblk_r;
    logic [STATUS_WIDTH-1:0] status_r;
    logic                    wr_acc, rd_acc, wr_eof_acc, rd_eof_acc;

    // Gating uses only registered flags so accept never depends on this cycle's transfer.
    assign wr_acc     = bus.WR_REQ & ~full_r;
    assign rd_acc     = bus.RD_REQ & ~empty_r;
    assign wr_eof_acc = wr_acc & bus.WR_EOF;
    assign rd_eof_acc = rd_acc & bus.RD_EOF;

    always_comb begin
        cnt_next  = cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        fcnt_next = fcnt;
        if (wr_eof_acc && !rd_eof_acc && fcnt != ITEMS_C)
            fcnt_next = fcnt + 1'b1;
        else if (!wr_eof_acc && rd_eof_acc && fcnt != '0)
            fcnt_next = fcnt - 1'b1;
        free_next = ITEMS_C - cnt_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt         <= '0;
            fcnt        <= '0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
            frame_rdy_r <= 1'b0;
            lstblk_r    <= 1'b0;
            status_r    <= STATUS_RST;
        end else begin
            cnt         <= cnt_next;
            fcnt        <= fcnt_next;
            empty_r     <= (cnt_next == '0);
            full_r      <= (cnt_next == ITEMS_C);
            frame_rdy_r <= (fcnt_next != '0);
            lstblk_r    <= (free_next <= BLOCK_C);
            status_r    <= free_next[CNT_W-1 -: STATUS_WIDTH];
        end
    end

`ifdef FL_FIFO_STATUS_ERR_EN
    logic err_r;
    logic err_event;

    // Underflowing EOF, or a read that drains the items while frames remain counted.
    assign err_event = (rd_eof_acc && !wr_eof_acc && fcnt == '0) ||
                       (rd_acc && cnt_next == '0 && fcnt_next != '0);

    always_ff @(posedge CLK) begin
        if (RESET)
            err_r <= 1'b0;
        else if (err_event)
            err_r <= 1'b1;
    end

    assign bus.ERR = err_r;
`endif

    assign bus.WR_ACCEPT = wr_acc;
    assign bus.RD_ACCEPT = rd_acc;
    assign bus.EMPTY     = empty_r;
    assign bus.FULL      = full_r;
    assign bus.FRAME_RDY = frame_rdy_r;
    assign bus.LSTBLK    = lstblk_r;
    assign bus.STATUS    = status_r;
endmodule
